// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FSM encoding and decode record for the alu_ctrl issue/writeback controller.
package alu_ctrl_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_OPRN_WIDTH = 6;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_MULI  = 6'h1d;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_NOP = 6'h00;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_ADD = 6'h01;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_SUB = 6'h02;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_MUL = 6'h03;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_SRL = 6'h04;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_SLL = 6'h05;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_AND = 6'h06;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OR  = 6'h07;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_NOR = 6'h08;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_SLT = 6'h09;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP2_REG     = 2'd0,
    OP2_IMM     = 2'd1,
    OP2_SIXTEEN = 2'd2
  } op2_sel_t;

  typedef struct packed {
    logic [ALU_OPRN_WIDTH-1:0] oprn;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic                      op1_imm;
    op2_sel_t                  op2_sel;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      illegal;
  } decode_t;

  function automatic logic [DATA_WIDTH-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext5(input logic [4:0] v);
    return {27'h0000000, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decode for alu_ctrl; I-type opcodes are decoded only when
// ALU_CTRL_IMM_OPS_EN is defined, otherwise every nonzero opcode is illegal.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] instr,
  output decode_t               dec
);

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  shamt_s;
  logic [15:0] imm_s;
  logic        unused_fields_s;

  assign opcode_s = instr[31:26];
  assign funct_s  = instr[5:0];
  assign shamt_s  = instr[10:6];
  assign imm_s    = instr[15:0];
  assign unused_fields_s = ^instr[25:16];

  // Map opcode/funct to ALU operation, destination and operand sources.
  always_comb begin
    dec         = '0;
    dec.op2_sel = OP2_REG;
    dec.dest    = instr[15:11];
    dec.illegal = 1'b0;
    case (opcode_s)
      OPC_RTYPE: begin
        case (funct_s)
          FN_ADD: dec.oprn = ALU_ADD;
          FN_SUB: dec.oprn = ALU_SUB;
          FN_MUL: dec.oprn = ALU_MUL;
          FN_AND: dec.oprn = ALU_AND;
          FN_OR:  dec.oprn = ALU_OR;
          FN_NOR: dec.oprn = ALU_NOR;
          FN_SLT: dec.oprn = ALU_SLT;
          FN_SRL: begin
            dec.oprn    = ALU_SRL;
            dec.op2_sel = OP2_IMM;
            dec.imm     = zext5(shamt_s);
          end
          FN_SLL: begin
            dec.oprn    = ALU_SLL;
            dec.op2_sel = OP2_IMM;
            dec.imm     = zext5(shamt_s);
          end
          default: dec.illegal = 1'b1;
        endcase
      end
`ifdef ALU_CTRL_IMM_OPS_EN
      OPC_ADDI: begin
        dec.oprn = ALU_ADD; dec.dest = instr[20:16];
        dec.op2_sel = OP2_IMM; dec.imm = sext16(imm_s);
      end
      OPC_MULI: begin
        dec.oprn = ALU_MUL; dec.dest = instr[20:16];
        dec.op2_sel = OP2_IMM; dec.imm = sext16(imm_s);
      end
      OPC_ANDI: begin
        dec.oprn = ALU_AND; dec.dest = instr[20:16];
        dec.op2_sel = OP2_IMM; dec.imm = zext16(imm_s);
      end
      OPC_ORI: begin
        dec.oprn = ALU_OR; dec.dest = instr[20:16];
        dec.op2_sel = OP2_IMM; dec.imm = zext16(imm_s);
      end
      OPC_SLTI: begin
        dec.oprn = ALU_SLT; dec.dest = instr[20:16];
        dec.op2_sel = OP2_IMM; dec.imm = sext16(imm_s);
      end
      // lui is a left shift of the zero-extended immediate by 16.
      OPC_LUI: begin
        dec.oprn = ALU_SLL; dec.dest = instr[20:16];
        dec.op1_imm = 1'b1; dec.op2_sel = OP2_SIXTEEN; dec.imm = zext16(imm_s);
      end
`endif
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Four-cycle issue/writeback controller in front of a combinational 32-bit ALU.
// Optional I-type decode is enabled by defining ALU_CTRL_IMM_OPS_EN.
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     INSTR,
  input  logic                      INSTR_VALID,
  output logic                      INSTR_READY,
  output logic [REG_ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [REG_ADDR_WIDTH-1:0] RF_ADDR_R2,
  input  logic [DATA_WIDTH-1:0]     RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0]     RF_DATA_R2,
  output logic [DATA_WIDTH-1:0]     ALU_OP1,
  output logic [DATA_WIDTH-1:0]     ALU_OP2,
  output logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN,
  input  logic [DATA_WIDTH-1:0]     ALU_OUT,
  input  logic                      ALU_ZERO,
  output logic                      WB_EN,
  output logic [REG_ADDR_WIDTH-1:0] WB_ADDR,
  output logic [DATA_WIDTH-1:0]     WB_DATA,
  output logic                      WB_ZERO,
  output logic                      ILLEGAL
);

  state_t                    state_r, next_s;
  logic [DATA_WIDTH-1:0]     instr_r;
  decode_t                   dec_s;
  logic                      ready_s, accept_s;
  logic [DATA_WIDTH-1:0]     op1_s, op2_s;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_r1_r, rf_addr_r2_r, wb_addr_r;
  logic [DATA_WIDTH-1:0]     alu_op1_r, alu_op2_r, wb_data_r;
  logic [ALU_OPRN_WIDTH-1:0] alu_oprn_r;
  logic                      wb_en_r, wb_zero_r, illegal_r;

  alu_ctrl_decode u_decode (
    .instr (instr_r),
    .dec   (dec_s)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; an illegal instruction returns straight to IDLE.
  always_comb begin
    next_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   next_s = accept_s ? ST_DECODE : ST_IDLE;
      ST_DECODE: next_s = dec_s.illegal ? ST_IDLE : ST_EXEC;
      ST_EXEC:   next_s = ST_WB;
      ST_WB:     next_s = ST_IDLE;
      default:   next_s = ST_IDLE;
    endcase
  end

  // Handshake: the ILLEGAL pulse cycle still counts as busy.
  always_comb begin
    ready_s  = (state_r == ST_IDLE) && !RST && !illegal_r;
    accept_s = INSTR_VALID && ready_s;
  end

  // Operand selection from register-file data and decoded immediate.
  always_comb begin
    op1_s = dec_s.op1_imm ? dec_s.imm : RF_DATA_R1;
    op2_s = RF_DATA_R2;
    case (dec_s.op2_sel)
      OP2_REG:     op2_s = RF_DATA_R2;
      OP2_IMM:     op2_s = dec_s.imm;
      OP2_SIXTEEN: op2_s = 32'd16;
      default:     op2_s = RF_DATA_R2;
    endcase
  end

  // Datapath registers; pulses default low and are raised only in their state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_r      <= 32'h0000_0000;
      rf_addr_r1_r <= 5'd0;
      rf_addr_r2_r <= 5'd0;
      alu_op1_r    <= 32'h0000_0000;
      alu_op2_r    <= 32'h0000_0000;
      alu_oprn_r   <= ALU_NOP;
      wb_en_r      <= 1'b0;
      wb_addr_r    <= 5'd0;
      wb_data_r    <= 32'h0000_0000;
      wb_zero_r    <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      illegal_r  <= 1'b0;
      wb_en_r    <= 1'b0;
      alu_oprn_r <= ALU_NOP;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            instr_r      <= INSTR;
            rf_addr_r1_r <= INSTR[25:21];
            rf_addr_r2_r <= INSTR[20:16];
          end
        end
        ST_DECODE: begin
          if (dec_s.illegal) begin
            illegal_r <= 1'b1;
          end else begin
            alu_op1_r  <= op1_s;
            alu_op2_r  <= op2_s;
            alu_oprn_r <= dec_s.oprn;
            wb_addr_r  <= dec_s.dest;
          end
        end
        // R0 is hardwired zero, so its writeback is suppressed but the data is kept.
        ST_EXEC: begin
          wb_data_r <= ALU_OUT;
          wb_zero_r <= ALU_ZERO;
          wb_en_r   <= (wb_addr_r != 5'd0);
        end
        ST_WB: begin
          wb_en_r <= 1'b0;
        end
        default: begin
          wb_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign INSTR_READY = ready_s;
  assign RF_ADDR_R1  = rf_addr_r1_r;
  assign RF_ADDR_R2  = rf_addr_r2_r;
  assign ALU_OP1     = alu_op1_r;
  assign ALU_OP2     = alu_op2_r;
  assign ALU_OPRN    = alu_oprn_r;
  assign WB_EN       = wb_en_r;
  assign WB_ADDR     = wb_addr_r;
  assign WB_DATA     = wb_data_r;
  assign WB_ZERO     = wb_zero_r;
  assign ILLEGAL     = illegal_r;

endmodule
